// File: rtl/aq_f_spsram_arb_ctrl.sv
// Two-requester round-robin front end for a single-port SRAM macro (active-low CEN/GWEN/WEN).
// An optional init pass zero-fills the whole array before any request is granted.
module aq_f_spsram_arb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_gnt,
  output logic                  req0_rvld,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_gnt,
  output logic                  req1_rvld,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic                  SRAM_CEN,
  output logic                  SRAM_GWEN,
  output logic [DATA_WIDTH-1:0] SRAM_WEN,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q,
  output logic                  dbg_state_o
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    init_done_q;
  logic                    last_q;
  logic                    req0_rvld_q, req1_rvld_q;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   d_q;
  logic                    run_act, init_act, gnt_any;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata, sel_wmask;

  assign run_act  = (state_q == ST_RUN)  && !RST;
  assign init_act = (state_q == ST_INIT) && !RST;

  // Handshake: reqN_vld is held by the requester until reqN_gnt is seen high in the
  // same cycle; that cycle is the SRAM access. Nothing is buffered here.
  // last_q=1 means req1 won most recently, so req0 takes the next conflict.
  always_comb begin
    req0_gnt = 1'b0;
    req1_gnt = 1'b0;
    if (run_act) begin
      if (req0_vld && req1_vld) begin
        req0_gnt = last_q;
        req1_gnt = ~last_q;
      end else begin
        req0_gnt = req0_vld;
        req1_gnt = req1_vld;
      end
    end
  end

  assign gnt_any   = req0_gnt | req1_gnt;
  assign sel_wr    = req1_gnt ? req1_wr    : req0_wr;
  assign sel_addr  = req1_gnt ? req1_addr  : req0_addr;
  assign sel_wdata = req1_gnt ? req1_wdata : req0_wdata;
  assign sel_wmask = req1_gnt ? req1_wmask : req0_wmask;

  // A and D keep their last driven value on idle cycles so the macro's Q stays put.
  always_comb begin
    SRAM_A    = a_q;
    SRAM_D    = d_q;
    SRAM_CEN  = 1'b1;
    SRAM_GWEN = 1'b1;
    SRAM_WEN  = '1;
    if (init_act) begin
      SRAM_A    = init_cnt_q;
      SRAM_D    = '0;
      SRAM_CEN  = 1'b0;
      SRAM_GWEN = 1'b0;
      SRAM_WEN  = '0;
    end else if (gnt_any) begin
      SRAM_A    = sel_addr;
      SRAM_D    = sel_wdata;
      SRAM_CEN  = 1'b0;
      SRAM_GWEN = ~sel_wr;
      SRAM_WEN  = sel_wr ? ~sel_wmask : '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= ~INIT_EN;
      last_q      <= 1'b1;
      req0_rvld_q <= 1'b0;
      req1_rvld_q <= 1'b0;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      a_q         <= SRAM_A;
      d_q         <= SRAM_D;
      req0_rvld_q <= req0_gnt & ~req0_wr;
      req1_rvld_q <= req1_gnt & ~req1_wr;
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          if (gnt_any) last_q <= req1_gnt;
        end
      endcase
    end
  end

  assign req0_rvld   = req0_rvld_q;
  assign req1_rvld   = req1_rvld_q;
  assign rdata       = SRAM_Q;
  assign init_done   = init_done_q;
  assign dbg_state_o = (state_q == ST_RUN);

endmodule
